// File: rtl/core_if_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// default fetch vectors, FSM state encodings and the prefetch entry layout.
package core_if_pkg;

  localparam logic [31:0] CORE_OPCODE_NOP  = 32'h0000_0013;
  localparam logic [31:0] CORE_IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] CORE_IF_FLUSH_PC = 32'h0000_0010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] ins;
  } if_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_if_queue.sv
// Prefetch FIFO between the fetch FSM and decode. Synchronous clear wins
// over push; push while full is accepted only alongside a pop.
module core_if_queue
  import core_if_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int AW = $clog2(QDEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  if_entry_t     wdata,
  output if_entry_t     rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  if_entry_t     mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/core_if.sv
// Instruction fetch stage: issues single outstanding word reads, buffers
// responses in a prefetch queue and hands one {ins, pc} per cycle to decode.
//
//   state   | meaning
//   IDLE    | no access outstanding; waits for queue room
//   REQ     | imem_req high at req_addr until imem_ack
module core_if
  import core_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CORE_IF_RESET_PC,
  parameter logic [31:0] FLUSH_PC = CORE_IF_FLUSH_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        imem_err,
  input  logic        id_halt,
  input  logic        id_flush,
  input  logic        branch,
  input  logic [31:0] branch_pc,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          discard;
  logic          redirect;
  logic [31:0]   target;
  logic          ack_ok;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [CW:0]   count_after;
  logic          room_after;
  if_entry_t     q_wdata;
  if_entry_t     q_rdata;

  assign redirect    = id_flush | branch;
  assign target      = id_flush ? word_align(FLUSH_PC) : word_align(branch_pc);
  assign ack_ok      = (state == ST_REQ) && imem_ack;
  assign q_push      = ack_ok && !discard && !redirect;
  assign q_pop       = !id_halt && !q_empty && !redirect;
  assign q_wdata     = '{err: imem_err, pc: req_addr, ins: imem_data};
  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = req_addr;
  assign count_after = {1'b0, q_count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, q_pop};
  assign room_after  = (count_after < (CW+1)'(QDEPTH));

  core_if_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // A redirect during an open access keeps the bus stable and marks the
  // eventual response for dropping; fetch_pc already holds the new target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= word_align(RESET_PC);
      req_addr <= word_align(RESET_PC);
      discard  <= 1'b0;
    end else begin
      if (redirect)               fetch_pc <= target;
      else if (ack_ok && !discard) fetch_pc <= req_addr + 32'd4;

      if (ack_ok)                            discard <= 1'b0;
      else if (redirect && state == ST_REQ)  discard <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!redirect && !q_full) begin
            state    <= ST_REQ;
            req_addr <= fetch_pc;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            if (redirect)        req_addr <= target;
            else if (discard)    req_addr <= fetch_pc;
            else if (room_after) req_addr <= req_addr + 32'd4;
            else                 state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_ins   <= CORE_OPCODE_NOP;
      if_pc    <= '0;
      if_valid <= 1'b0;
      if_err   <= 1'b0;
    end else if (redirect) begin
      if_ins   <= CORE_OPCODE_NOP;
      if_valid <= 1'b0;
      if_err   <= 1'b0;
    end else if (!id_halt) begin
      if (!q_empty) begin
        if_ins   <= q_rdata.err ? CORE_OPCODE_NOP : q_rdata.ins;
        if_pc    <= q_rdata.pc;
        if_err   <= q_rdata.err;
        if_valid <= 1'b1;
      end else begin
        if_ins   <= CORE_OPCODE_NOP;
        if_valid <= 1'b0;
        if_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_if.sv
// Directed bench for core_if: a memory responder feeds a scoreboard of
// expected {pc, ins, err} entries that is checked as decode consumes them.
module tb_core_if;
  import core_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        imem_err = 1'b0;
  logic        id_halt = 1'b0;
  logic        id_flush = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_pc = '0;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_err;

  core_if #(.RESET_PC(32'h0000_0000), .FLUSH_PC(32'h0000_0010), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .imem_err(imem_err),
    .id_halt(id_halt), .id_flush(id_flush), .branch(branch), .branch_pc(branch_pc),
    .if_ins(if_ins), .if_pc(if_pc), .if_valid(if_valid), .if_err(if_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  logic        s_rst = 1'b1, s_halt = 1'b0, s_flush = 1'b0, s_branch = 1'b0;
  logic [31:0] s_bpc = '0;
  int          ack_delay = 0, wait_cnt = 0;
  bit          hold_ack = 0, stray = 0, err_en = 0, drop_pending = 0, last_take = 0, seen_err = 0;
  logic [31:0] err_addr = '0, exp_addr = '0, pend_target = '0;
  logic [31:0] last_pc = '0, last_ins = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] tgt;
    bit          redir;
    @(negedge clk);
    if (last_take) begin
      if (sb.size() == 0) check("valid_no_entry", 32'(if_valid), 32'd0);
      else if (if_valid === 1'b1) begin
        e = sb.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_ins", if_ins, e.ins);
        check("if_err", 32'(if_err), 32'(e.err));
        if (e.err) seen_err = 1;
        last_pc = e.pc; last_ins = e.ins;
        n_pop++;
      end
    end
    rst = s_rst; id_halt = s_halt; id_flush = s_flush; branch = s_branch; branch_pc = s_bpc;
    imem_ack = 1'b0; imem_err = 1'b0; imem_data = '0;
    redir = !s_rst && (s_flush || s_branch);
    tgt = s_flush ? 32'h0000_0010 : {s_bpc[31:2], 2'b00};
    if (s_rst) begin
      sb.delete(); drop_pending = 0; exp_addr = 32'h0; wait_cnt = 0;
    end
    if (stray) begin
      imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    end else if (!s_rst && imem_req === 1'b1 && !hold_ack) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ 32'hA5A5_0000;
        imem_err  = err_en && (imem_addr == err_addr);
        check("imem_addr", imem_addr, exp_addr);
        wait_cnt = 0;
        if (!redir) begin
          if (drop_pending) begin
            drop_pending = 0; exp_addr = pend_target;
          end else begin
            e.pc  = exp_addr;
            e.err = err_en && (exp_addr == err_addr);
            e.ins = e.err ? CORE_OPCODE_NOP : (exp_addr ^ 32'hA5A5_0000);
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
          end
        end
      end else wait_cnt++;
    end else wait_cnt = 0;
    if (redir) begin
      sb.delete();
      if (imem_ack) begin drop_pending = 0; exp_addr = tgt; end
      else if (imem_req === 1'b1) begin drop_pending = 1; pend_target = tgt; end
      else exp_addr = tgt;
    end
    @(posedge clk);
    last_take = !s_rst && !s_halt && !redir;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    s_rst = 1; run(2); s_rst = 0;
  endtask

  initial begin
    int cnt;
    int p0;
    bit found;

    // reset state
    ack_delay = 0;
    run(2);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ins", if_ins, CORE_OPCODE_NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_err", 32'(if_err), 32'd0);

    // 1: streaming fetch, N+2 latency then one per cycle
    s_rst = 0;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("lat_n1_valid", 32'(if_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(if_valid), 32'd1);
    check("lat_n2_pc", if_pc, 32'h0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_valid === 1'b1) cnt++;
    end
    check("stream_count", 32'(cnt), 32'd6);

    // 2: decode halt freezes outputs, queue fills, fetch idles
    s_halt = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_pc", if_pc, last_pc);
      check("halt_ins", if_ins, last_ins);
    end
    check("halt_req_idle", 32'(imem_req), 32'd0);
    s_halt = 0;
    p0 = n_pop;
    run(10);
    check("halt_resume", 32'(n_pop > p0 + 5), 32'd1);

    // 3: branch while an access is outstanding
    do_reset();
    ack_delay = 3;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (imem_req === 1'b1 && imem_addr == 32'h20) found = 1;
    end
    check("find_req_0x20", 32'(found), 32'd1);
    s_branch = 1; s_bpc = 32'h0000_0103;
    tick();
    s_branch = 0;
    check("br_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("br_hold_addr", imem_addr, 32'h20);
      check("br_hold_req", 32'(imem_req), 32'd1);
      tick();
    end
    check("br_hold_addr_last", imem_addr, 32'h20);
    tick();
    check("br_new_addr", imem_addr, 32'h100);
    check("br_new_req", 32'(imem_req), 32'd1);
    check("br_no_valid", 32'(if_valid), 32'd0);
    p0 = n_pop;
    run(20);
    check("br_target_seen", 32'(n_pop > p0), 32'd1);

    // 4: flush and branch together with an ack
    do_reset();
    ack_delay = 0;
    run(5);
    check("fl_req_before", 32'(imem_req), 32'd1);
    s_flush = 1; s_branch = 1; s_bpc = 32'h40;
    tick();
    s_flush = 0; s_branch = 0;
    check("fl_req", 32'(imem_req), 32'd1);
    check("fl_addr", imem_addr, 32'h10);
    check("fl_valid", 32'(if_valid), 32'd0);
    p0 = n_pop;
    run(8);
    check("fl_stream", 32'(n_pop > p0 + 3), 32'd1);

    // 5: bus error on 0x8
    do_reset();
    err_en = 1; err_addr = 32'h8;
    seen_err = 0;
    run(10);
    check("err_seen", 32'(seen_err), 32'd1);
    err_en = 0;

    // 6: wrap at top of address space, then reset with an access outstanding
    s_branch = 1; s_bpc = 32'hFFFF_FFF8;
    tick();
    s_branch = 0;
    p0 = n_pop;
    run(6);
    check("wrap_stream", 32'(n_pop > p0 + 3), 32'd1);
    hold_ack = 1;
    run(2);
    check("out_req", 32'(imem_req), 32'd1);
    s_rst = 1;
    tick();
    check("rst2_req", 32'(imem_req), 32'd0);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_ins", if_ins, CORE_OPCODE_NOP);
    check("rst2_pc", if_pc, 32'h0);
    check("rst2_valid", 32'(if_valid), 32'd0);
    check("rst2_err", 32'(if_err), 32'd0);
    s_rst = 0; stray = 1;
    tick();
    stray = 0; hold_ack = 0;
    check("stray_valid", 32'(if_valid), 32'd0);
    check("stray_req", 32'(imem_req), 32'd1);
    check("stray_addr", imem_addr, 32'h0);
    p0 = n_pop;
    run(6);
    check("post_rst_stream", 32'(n_pop > p0 + 2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
